imem_arbiter: RTL

Arbiter that shares one single-ported, synchronous-read instruction/BIOS memory between the instruction-fetch port of the IF stage and a data port used by MEM-stage loads/stores to that memory region. It grants one requester per cycle, raises a fetch stall toward the program counter when fetch loses, and routes each one-cycle-latency read response back to its owner. A burst limiter keeps data traffic from starving fetch.

---
 rtl/imem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-ported, synchronous-read instruction/BIOS
// memory between the IF-stage fetch port and a MEM-stage data port.
//
// - One grant per cycle, decided combinationally. Data normally wins a
//   conflict. A burst limiter hands the slot to fetch after MAX_DATA_BURST
//   consecutive data grants that fetch spent waiting.
// - A small response tracker remembers who owns the read issued last cycle
//   and steers the one-cycle-latency read data back to that owner.
// - Optional build macro: IMEM_ARB_PERF_EN adds a 32-bit conflict_cnt output
//   that counts cycles in which both ports request.
// - Debug outputs rsp_state and burst_level expose the internal state so
//   checkers can bind to them.
//
// Handshake: a requester raises *_req with a stable address. The request
// completes in the cycle where it is granted: fetch sees if_stall == 0, data
// sees d_gnt == 1. Until then the requester holds req/addr/data unchanged;
// the arbiter keeps no queue. Read data returns exactly one cycle after the
// grant, qualified by the matching *_rvalid. Writes return nothing.
module imem_arbiter #(
   parameter int ADDR_W         = 12,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   // instruction-fetch port
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   input  logic              if_kill,
   output logic              if_stall,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   // data port
   input  logic              d_req,
   input  logic [3:0]        d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   // memory port
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
`ifdef IMEM_ARB_PERF_EN
   output logic [31:0]       conflict_cnt,
`endif
   // debug visibility
   output logic [1:0]        rsp_state,
   output logic [3:0]        burst_level
);

   // Response tracker encoding: who owns the read currently in flight.
   localparam logic [1:0] RSP_IDLE  = 2'd0;
   localparam logic [1:0] RSP_FETCH = 2'd1;
   localparam logic [1:0] RSP_DATA  = 2'd2;

   localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

   logic [1:0] rsp;
   logic [1:0] rsp_next;
   logic [3:0] burst_cnt;
   logic       burst_full;
   logic       fetch_grant;
   logic       data_grant;
   logic       data_read;

   // Only the word-address bits reach the memory. The byte offset and the
   // region-decode bits above it are dropped on purpose.
   logic       unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                               d_addr[31:ADDR_W+2],  d_addr[1:0]};

   assign burst_full = (burst_cnt == BURST_MAX);

   // Grant decision. Reset holds both grants low, so the memory is never
   // enabled while rst is high.
   always_comb begin
      fetch_grant = 1'b0;
      data_grant  = 1'b0;
      if (!rst) begin
         if (if_req && d_req) begin
            if (burst_full) begin
               fetch_grant = 1'b1;
            end else begin
               data_grant = 1'b1;
            end
         end else if (if_req) begin
            fetch_grant = 1'b1;
         end else if (d_req) begin
            data_grant = 1'b1;
         end
      end
   end

   assign data_read = data_grant && (d_we == 4'b0000);

   // Requester-side handshake outputs.
   assign if_stall = if_req & ~fetch_grant;
   assign d_gnt    = data_grant;

   // Memory port. The address mux favours data when idle; mem_en qualifies it.
   assign mem_en    = fetch_grant | data_grant;
   assign mem_we    = data_grant ? d_we : 4'b0000;
   assign mem_addr  = fetch_grant ? if_addr[ADDR_W+1:2] : d_addr[ADDR_W+1:2];
   assign mem_wdata = d_wdata;

   // Burst limiter. It counts data grants only while fetch is waiting. It
   // restarts once fetch is served or stops asking, and it sticks at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt <= 4'd0;
      end else if (fetch_grant || !if_req) begin
         burst_cnt <= 4'd0;
      end else if (data_grant && !burst_full) begin
         burst_cnt <= burst_cnt + 4'd1;
      end
   end

   // Next owner of the memory read data. Writes leave nothing pending.
   always_comb begin
      rsp_next = RSP_IDLE;
      if (fetch_grant) begin
         rsp_next = RSP_FETCH;
      end else if (data_read) begin
         rsp_next = RSP_DATA;
      end
   end

   // Response tracker register. An asynchronous reset discards any in-flight
   // read, so no rvalid follows it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp <= RSP_IDLE;
      end else begin
         rsp <= rsp_next;
      end
   end

   // Response routing. A kill masks the fetch response presented in the same
   // cycle, which is the one already in flight. A fetch granted alongside the
   // kill belongs to the new stream and comes back normally one cycle later.
   assign if_rvalid = (rsp == RSP_FETCH) & ~if_kill;
   assign d_rvalid  = (rsp == RSP_DATA);
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;

`ifdef IMEM_ARB_PERF_EN
   // Contention counter. It counts every cycle where both ports ask, and it
   // wraps naturally at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= 32'd0;
      end else if (if_req && d_req) begin
         conflict_cnt <= conflict_cnt + 32'd1;
      end
   end
`endif

   assign rsp_state   = rsp;
   assign burst_level = burst_cnt;

endmodule
